// File: rtl/mem_data_path.sv
// mem_data_path
//   MAR/MDR register pair and fixed-latency memory-access sequencer. MAR and
//   MDR load from the datapath bus; MDR also feeds the bus mux. Each access
//   holds one strobe for MEM_WAIT cycles, then pulses done for one cycle.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for mem_start; LD_MAR/LD_MDR accepted
//   ACCESS | strobe of latched op high for MEM_WAIT cycles; loads ignored
//   DONE   | one-cycle done pulse; LD_MAR/LD_MDR accepted, mem_start ignored
//
// Ports
//   Clk, Reset           clock (rising edge), async active-high reset
//   bus_in               datapath bus value, source for MAR/MDR loads
//   LD_MAR, LD_MDR       register load enables (IDLE/DONE only)
//   mem_start, mem_we    access request and direction (1 = write)
//   mem_rdata            SRAM read data, captured on the last ACCESS edge
//   mar_out, mdr_out     register contents
//   mem_addr, mem_wdata  SRAM address / write data (= MAR / MDR)
//   mem_rd, mem_wr       SRAM strobes, high throughout ACCESS
//   busy, done           ACCESS indicator, one-cycle completion pulse
module mem_data_path #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int MEM_WAIT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              mem_start,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mar_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              busy,
  output logic              done
);

  // Counter must be able to hold MEM_WAIT itself: the exit compare is made
  // against the incremented value.
  localparam int CNT_W = (MEM_WAIT < 2) ? 1 : $clog2(MEM_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic                last_cycle;

  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign last_cycle = (cnt_inc == CNT_W'(MEM_WAIT));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      mar_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    case (state_q)
      S_IDLE: begin
        // Loads and start share the edge, so a same-edge start sees the new MAR/MDR.
        if (LD_MAR) mar_d = bus_in[ADDR_W-1:0];
        if (LD_MDR) mdr_d = bus_in;
        if (mem_start) begin
          we_d    = mem_we;
          cnt_d   = '0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_inc;
        if (last_cycle) begin
          state_d = S_DONE;
          if (!we_q) mdr_d = mem_rdata;
        end
      end
      S_DONE: begin
        if (LD_MAR) mar_d = bus_in[ADDR_W-1:0];
        if (LD_MDR) mdr_d = bus_in;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pure state decode: async reset to IDLE drops strobes immediately.
  assign busy      = (state_q == S_ACCESS);
  assign mem_rd    = busy && !we_q;
  assign mem_wr    = busy && we_q;
  assign done      = (state_q == S_DONE);
  assign mar_out   = mar_q;
  assign mdr_out   = mdr_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;

endmodule
